// File: rtl/path_sequencer.sv
// path_sequencer
//
// Buffers a planned node sequence (travel order, start node first), looks up
// the absolute heading of every edge in an external direction ROM and issues
// one relative turn command per segment. The next segment is only started
// once the line follower reports the current target intersection reached.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     node stream from the planner (in_node, in_last,
//                         start_heading sampled with the first node)
//   hd_req/hd_src/hd_dst  direction ROM read; hd_dir returns one cycle later
//   node_reached          1-cycle pulse from the line follower
//   cmd_valid/cmd_ready   turn command (cmd_turn, cmd_node, cmd_last)
//   busy, done            status; done pulses once per completed path
//   err                   sticky: [0] buffer overflow, [1] node_reached overrun
//   dbg_state             current FSM state for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. cmd_* stays stable while cmd_valid is high and cmd_ready is low.
module path_sequencer #(
    parameter int NODE_W = 8,
    parameter int DEPTH  = 64,
    parameter int AW     = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NODE_W-1:0] in_node,
    input  logic              in_last,
    input  logic [1:0]        start_heading,
    output logic              hd_req,
    output logic [NODE_W-1:0] hd_src,
    output logic [NODE_W-1:0] hd_dst,
    input  logic [1:0]        hd_dir,
    input  logic              node_reached,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [1:0]        cmd_turn,
    output logic [NODE_W-1:0] cmd_node,
    output logic              cmd_last,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        LOOKUP    = 3'd2,
        ROM_WAIT  = 3'd3,
        ISSUE     = 3'd4,
        WAIT_NODE = 3'd5,
        DONE      = 3'd6
    } state_t;

    localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

    state_t            state_q, state_d;
    // Pointers and length are one bit wider than the address so that a
    // completely full buffer (DEPTH entries) is representable.
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]       len_q, len_d;
    logic [1:0]        heading_q, heading_d;
    logic [1:0]        dir_q, dir_d;
    logic [1:0]        turn_q, turn_d;
    logic              flag_q, flag_d;
    logic [1:0]        err_q, err_d;

    logic [NODE_W-1:0] path_mem [DEPTH];
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [AW-1:0]     rd_addr;
    logic [AW-1:0]     rd_addr_nxt;

    assign rd_addr     = rd_ptr_q[AW-1:0];
    assign rd_addr_nxt = rd_ptr_q[AW-1:0] + 1'b1;

    // Path storage is not reset; every read is gated by state so stale
    // contents never reach the outputs.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            path_mem[mem_waddr] <= in_node;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            len_q     <= '0;
            heading_q <= '0;
            dir_q     <= '0;
            turn_q    <= '0;
            flag_q    <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            len_q     <= len_d;
            heading_q <= heading_d;
            dir_q     <= dir_d;
            turn_q    <= turn_d;
            flag_q    <= flag_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        len_d     = len_q;
        heading_d = heading_q;
        dir_d     = dir_q;
        turn_d    = turn_q;
        flag_d    = flag_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_q[AW-1:0];

        // An arrival reported outside WAIT_NODE is remembered; a second one
        // before it is consumed is an overrun and still counts only once.
        // Evaluated before the state case so DONE's clear takes priority.
        if (node_reached && (state_q != IDLE) && (state_q != WAIT_NODE)) begin
            if (flag_q) begin
                err_d[1] = 1'b1;
            end
            flag_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = '0;
                    wr_ptr_d  = (AW+1)'(1);
                    rd_ptr_d  = '0;
                    heading_d = start_heading;
                    if (in_last) begin
                        len_d   = (AW+1)'(1);
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (in_valid) begin
                    // A full buffer drops nodes but keeps accepting, so the
                    // planner never stalls.
                    if (wr_ptr_q == DEPTH_P) begin
                        err_d[0] = 1'b1;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                    if (in_last) begin
                        len_d    = wr_ptr_d;
                        rd_ptr_d = '0;
                        state_d  = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                state_d = ROM_WAIT;
            end
            ROM_WAIT: begin
                dir_d   = hd_dir;
                // Relative turn is the clockwise heading difference mod 4.
                turn_d  = hd_dir - heading_q;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (cmd_ready) begin
                    heading_d = dir_q;
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                    state_d   = WAIT_NODE;
                end
            end
            WAIT_NODE: begin
                if (node_reached || flag_q) begin
                    flag_d = 1'b0;
                    if ((rd_ptr_q + 1'b1) == len_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOOKUP;
                    end
                end
            end
            DONE: begin
                flag_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // in_ready is gated by rst_n so it is low while reset is asserted even
    // though the state register already reads IDLE.
    assign in_ready  = rst_n && ((state_q == IDLE) || (state_q == LOAD));
    assign hd_req    = (state_q == LOOKUP);
    assign hd_src    = hd_req ? path_mem[rd_addr] : '0;
    assign hd_dst    = hd_req ? path_mem[rd_addr_nxt] : '0;
    assign cmd_valid = (state_q == ISSUE);
    assign cmd_turn  = cmd_valid ? turn_q : 2'b00;
    assign cmd_node  = cmd_valid ? path_mem[rd_addr_nxt] : '0;
    assign cmd_last  = cmd_valid && ((rd_ptr_q + (AW+1)'(2)) == len_q);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_path_sequencer.sv
// Self-checking bench for path_sequencer. All stimulus is applied and all
// outputs are sampled on the falling clock edge.
module tb_path_sequencer;
  localparam int NODE_W = 8;
  localparam int DEPTH  = 64;
  localparam int AW     = 6;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [NODE_W-1:0] in_node;
  logic              in_last;
  logic [1:0]        start_heading;
  logic              hd_req;
  logic [NODE_W-1:0] hd_src;
  logic [NODE_W-1:0] hd_dst;
  logic [1:0]        hd_dir;
  logic              node_reached;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_turn;
  logic [NODE_W-1:0] cmd_node;
  logic              cmd_last;
  logic              busy;
  logic              done;
  logic [1:0]        err;
  logic [2:0]        dbg_state;

  path_sequencer #(.NODE_W(NODE_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_node(in_node), .in_last(in_last), .start_heading(start_heading),
    .hd_req(hd_req), .hd_src(hd_src), .hd_dst(hd_dst), .hd_dir(hd_dir),
    .node_reached(node_reached), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_turn(cmd_turn), .cmd_node(cmd_node), .cmd_last(cmd_last),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [NODE_W+2:0] exp_q[$];   // {turn, node, last}
  logic [NODE_W-1:0] path_q[$];
  int n_cmp;
  int n_fail;

  // Direction ROM: a few fixed edges for the directed path, a hash elsewhere.
  function automatic logic [1:0] rom_dir(input logic [NODE_W-1:0] s, input logic [NODE_W-1:0] d);
    logic [NODE_W-1:0] h;
    if (s == 8'd33 && d == 8'd31) return 2'd1;
    if (s == 8'd31 && d == 8'd28) return 2'd0;
    if (s == 8'd28 && d == 8'd3)  return 2'd3;
    h = 8'(s * 8'd3 + d * 8'd7 + (s >> 2));
    return h[1:0];
  endfunction

  // ROM answers one cycle after the strobe.
  always @(posedge clk) hd_dir <= hd_req ? rom_dir(hd_src, hd_dst) : 2'b00;

  // Reference model: walk the (capped) path and derive every command.
  task automatic build_exp(input logic [1:0] sh);
    int n;
    logic [1:0] h, d, t;
    exp_q.delete();
    n = (path_q.size() > DEPTH) ? DEPTH : path_q.size();
    h = sh;
    for (int i = 0; i < n - 1; i++) begin
      d = rom_dir(path_q[i], path_q[i+1]);
      t = d - h;
      exp_q.push_back({t, path_q[i+1], (i == n - 2) ? 1'b1 : 1'b0});
      h = d;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_nodes(input logic [1:0] sh);
    for (int i = 0; i < path_q.size(); i++) begin
      in_valid      = 1'b1;
      in_node       = path_q[i];
      in_last       = (i == path_q.size() - 1);
      start_heading = (i == 0) ? sh : 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_cmd(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (cmd_valid) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; in_valid = 0; in_node = 0; in_last = 0; start_heading = 0;
    node_reached = 0; cmd_ready = 0;
    #3;
    n_cmp++;
    if ({in_ready, hd_req, cmd_valid, busy, done, err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=0000000", {in_ready, hd_req, cmd_valid, busy, done, err});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release in_ready=%b busy=%b exp 1/0", in_ready, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_directed;
    int exp_node[3] = '{31, 28, 3};
    int exp_turn[3] = '{1, 3, 3};
    path_q = '{8'd33, 8'd31, 8'd28, 8'd3};
    send_nodes(2'd0);
    n_cmp++;
    if (hd_req !== 1'b1 || hd_src !== 8'd33 || hd_dst !== 8'd31) begin
      n_fail++;
      $display("FAIL dir_first_lookup req=%b src=%0d dst=%0d exp 1/33/31", hd_req, hd_src, hd_dst);
    end
    @(negedge clk);
    n_cmp++;
    if (cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL dir_rom_wait cmd_valid=%b exp 0", cmd_valid);
    end
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      n_cmp++;
      if ({cmd_valid, cmd_turn, cmd_node, cmd_last} !== {1'b1, 2'(exp_turn[s]), 8'(exp_node[s]), (s == 2)}) begin
        n_fail++;
        $display("FAIL dir_cmd%0d got v=%b t=%0d n=%0d l=%b exp v=1 t=%0d n=%0d l=%0d",
                 s, cmd_valid, cmd_turn, cmd_node, cmd_last, exp_turn[s], exp_node[s], s == 2);
      end
      cmd_ready = 1'b1; @(negedge clk); cmd_ready = 1'b0;
      for (int w = 0; w < 3; w++) begin
        n_cmp++;
        if (cmd_valid !== 1'b0 || hd_req !== 1'b0 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL dir_wait_node seg=%0d v=%b req=%b done=%b exp 0", s, cmd_valid, hd_req, done);
        end
        @(negedge clk);
      end
      node_reached = 1'b1; @(negedge clk); node_reached = 1'b0;
      if (s < 2) begin
        n_cmp++;
        if (hd_req !== 1'b1 || hd_src !== 8'(exp_node[s])) begin
          n_fail++;
          $display("FAIL dir_lookup_latency seg=%0d req=%b src=%0d exp 1/%0d", s, hd_req, hd_src, exp_node[s]);
        end
        repeat (2) @(negedge clk);
      end else begin
        n_cmp++;
        if (done !== 1'b1) begin
          n_fail++;
          $display("FAIL dir_done got=%b exp=1", done);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL dir_idle done=%b in_ready=%b busy=%b exp 0/1/0", done, in_ready, busy);
        end
      end
    end
  endtask

  task automatic test_single;
    path_q = '{8'd7};
    send_nodes(2'd2);
    n_cmp++;
    if (done !== 1'b1 || hd_req !== 1'b0 || cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done done=%b req=%b v=%b exp 1/0/0", done, hd_req, cmd_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || in_ready !== 1'b1 || hd_req !== 1'b0 || cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle done=%b in_ready=%b req=%b v=%b exp 0/1/0/0", done, in_ready, hd_req, cmd_valid);
    end
  endtask

  task automatic test_random;
    bit to;
    logic [1:0] sh;
    logic [NODE_W+2:0] e;
    for (int p = 0; p < 6; p++) begin
      path_q.delete();
      for (int i = 0; i < $urandom_range(2, 12); i++) path_q.push_back(8'($urandom_range(0, 255)));
      sh = 2'($urandom_range(0, 3));
      build_exp(sh);
      send_nodes(sh);
      while (exp_q.size() > 0) begin
        wait_cmd(to);
        n_cmp++;
        if (to) begin
          n_fail++;
          $display("FAIL rnd_cmd_timeout path=%0d cmd_valid=%b exp 1", p, cmd_valid);
          break;
        end
        e = exp_q.pop_front();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        n_cmp++;
        if ({cmd_valid, cmd_turn, cmd_node, cmd_last} !== {1'b1, e}) begin
          n_fail++;
          $display("FAIL rnd_cmd path=%0d got t=%0d n=%0d l=%b exp t=%0d n=%0d l=%b",
                   p, cmd_turn, cmd_node, cmd_last, e[NODE_W+2:NODE_W+1], e[NODE_W:1], e[0]);
        end
        cmd_ready = 1'b1; @(negedge clk); cmd_ready = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        node_reached = 1'b1; @(negedge clk); node_reached = 1'b0;
      end
      n_cmp++;
      if (done !== 1'b1 || err !== 2'b00) begin
        n_fail++;
        $display("FAIL rnd_done path=%0d done=%b err=%b exp 1/00", p, done, err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_pending;
    logic [NODE_W+2:0] e;
    path_q = '{8'd10, 8'd20, 8'd30};
    build_exp(2'd2);
    send_nodes(2'd2);
    repeat (2) @(negedge clk);
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({cmd_valid, cmd_turn, cmd_node, cmd_last} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL stall_hold cyc=%0d got v=%b t=%0d n=%0d l=%b exp v=1 t=%0d n=%0d l=%b", i,
                 cmd_valid, cmd_turn, cmd_node, cmd_last, e[NODE_W+2:NODE_W+1], e[NODE_W:1], e[0]);
      end
      node_reached = (i == 0);
      @(negedge clk);
      node_reached = 1'b0;
    end
    cmd_ready = 1'b1; @(negedge clk); cmd_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (hd_req !== 1'b1 || hd_src !== 8'd20 || err !== 2'b00) begin
      n_fail++;
      $display("FAIL pending_lookup req=%b src=%0d err=%b exp 1/20/00", hd_req, hd_src, err);
    end
    repeat (2) @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if ({cmd_valid, cmd_turn, cmd_node, cmd_last} !== {1'b1, e}) begin
      n_fail++;
      $display("FAIL pending_cmd2 got v=%b t=%0d n=%0d l=%b exp t=%0d n=%0d l=%b",
               cmd_valid, cmd_turn, cmd_node, cmd_last, e[NODE_W+2:NODE_W+1], e[NODE_W:1], e[0]);
    end
    node_reached = 1'b1; @(negedge clk); node_reached = 1'b0;
    @(negedge clk);
    node_reached = 1'b1; @(negedge clk); node_reached = 1'b0;
    n_cmp++;
    if (err !== 2'b10 || cmd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_err err=%b v=%b exp 10/1", err, cmd_valid);
    end
    cmd_ready = 1'b1; @(negedge clk); cmd_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || err !== 2'b10) begin
      n_fail++;
      $display("FAIL pending_done done=%b err=%b exp 1/10", done, err);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow;
    bit to;
    bit dropped;
    int served;
    logic [1:0] sh;
    logic [NODE_W+2:0] e;
    path_q.delete();
    for (int i = 0; i < 70; i++) path_q.push_back(8'($urandom_range(0, 255)));
    sh = 2'($urandom_range(0, 3));
    build_exp(sh);
    dropped = 1'b0;
    for (int i = 0; i < 70; i++) begin
      if (in_ready !== 1'b1) dropped = 1'b1;
      in_valid = 1'b1; in_node = path_q[i]; in_last = (i == 69);
      start_heading = (i == 0) ? sh : 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    n_cmp++;
    if (dropped || err !== 2'b11) begin
      n_fail++;
      $display("FAIL overflow_load in_ready_dropped=%b err=%b exp 0/11", dropped, err);
    end
    served = 0;
    while (exp_q.size() > 0) begin
      wait_cmd(to);
      n_cmp++;
      if (to) begin
        n_fail++;
        $display("FAIL ovf_cmd_timeout served=%0d cmd_valid=%b exp 1", served, cmd_valid);
        break;
      end
      e = exp_q.pop_front();
      n_cmp++;
      if ({cmd_turn, cmd_node, cmd_last} !== e) begin
        n_fail++;
        $display("FAIL ovf_cmd seg=%0d got t=%0d n=%0d l=%b exp t=%0d n=%0d l=%b",
                 served, cmd_turn, cmd_node, cmd_last, e[NODE_W+2:NODE_W+1], e[NODE_W:1], e[0]);
      end
      served++;
      cmd_ready = 1'b1; @(negedge clk); cmd_ready = 1'b0;
      node_reached = 1'b1; @(negedge clk); node_reached = 1'b0;
    end
    n_cmp++;
    if (served != 63 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_segments served=%0d done=%b exp 63/1", served, done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit to;
    logic [NODE_W+2:0] e;
    path_q = '{8'd5, 8'd6, 8'd9};
    send_nodes(2'd1);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (cmd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre_issue cmd_valid=%b exp 1", cmd_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_valid, cmd_turn, cmd_node, cmd_last, in_ready, busy, done, hd_req, hd_src, hd_dst, err} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs v=%b t=%b n=%0d l=%b rdy=%b busy=%b done=%b req=%b err=%b exp all 0",
               cmd_valid, cmd_turn, cmd_node, cmd_last, in_ready, busy, done, hd_req, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    path_q = '{8'd40, 8'd41};
    build_exp(2'd3);
    send_nodes(2'd3);
    wait_cmd(to);
    e = exp_q.pop_front();
    n_cmp++;
    if (to || {cmd_turn, cmd_node, cmd_last} !== e) begin
      n_fail++;
      $display("FAIL post_reset_cmd to=%b got t=%0d n=%0d l=%b exp t=%0d n=%0d l=%b",
               to, cmd_turn, cmd_node, cmd_last, e[NODE_W+2:NODE_W+1], e[NODE_W:1], e[0]);
    end
    cmd_ready = 1'b1; @(negedge clk); cmd_ready = 1'b0;
    node_reached = 1'b1; @(negedge clk); node_reached = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || err !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset_done done=%b err=%b exp 1/00", done, err);
    end
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_directed();
    test_single();
    test_random();
    test_pending();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/path_sequencer.md
# path_sequencer

Downstream consumer of the Dijkstra path planner. Buffers the planned node sequence (travel order, start node first), looks up the absolute heading of each edge in an external direction ROM, and issues one relative turn command per segment to the motion/line-follower stage. Advances to the next segment only when the line follower reports the current target intersection reached.

## Interface

Parameters:

- NODE_W, default 8, node ID width.
- DEPTH, default 64, path buffer entries (power of two).
- AW, default 6, buffer address width, log2(DEPTH).

Ports:

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  path node valid from planner.
- in_ready  out  1  sequencer accepts a node.
- in_node  in  NODE_W  node ID.
- in_last  in  1  final node of path.
- start_heading  in  2  robot heading at start node (N=0, E=1, S=2, W=3, clockwise); sampled with first node.
- hd_req  out  1  direction ROM read strobe.
- hd_src, hd_dst  out  NODE_W each  edge endpoints for lookup.
- hd_dir  in  2  absolute edge heading; valid exactly 1 cycle after hd_req.
- node_reached  in  1  1-cycle pulse from line follower at an intersection.
- cmd_valid  out  1  turn command valid.
- cmd_ready  in  1  motion stage accepts command.
- cmd_turn  out  2  00 straight, 01 right, 10 U-turn, 11 left.
- cmd_node  out  NODE_W  segment destination node.
- cmd_last  out  1  segment ends at final node.
- busy  out  1  high in any state except IDLE.
- done  out  1  1-cycle pulse on path completion.
- err  out  2  sticky: [0] buffer overflow, [1] node_reached overrun.

## Operation

- States: IDLE, LOAD, LOOKUP, ROM_WAIT, ISSUE, WAIT_NODE, DONE.
- IDLE: in_ready=1. The first accepted node goes to buf[0], sets wr_ptr=1, and latches heading=start_heading. With in_last=1, go to DONE and issue no commands. Otherwise go to LOAD.
- LOAD: in_ready=1. Nodes are written at wr_ptr. When wr_ptr==DEPTH, further nodes are discarded and err[0] is set; in_ready stays 1 so the planner never stalls. Accepting in_last sets len=wr_ptr after the write, sets rd_ptr=0, and goes to LOOKUP.
- LOOKUP (1 cycle): hd_req=1, hd_src=buf[rd_ptr], hd_dst=buf[rd_ptr+1]; go to ROM_WAIT.
- ROM_WAIT (1 cycle): capture dir=hd_dir and turn=(dir-heading) mod 4, using 2-bit wrap arithmetic; go to ISSUE.
- ISSUE: cmd_valid=1 with registered cmd_turn, cmd_node=buf[rd_ptr+1], and cmd_last=(rd_ptr+2==len). Outputs hold stable until cmd_ready. On the handshake: heading←dir, rd_ptr←rd_ptr+1, go to WAIT_NODE.
- WAIT_NODE: on node_reached or the pending flag, clear the flag. If rd_ptr+1==len, go to DONE; otherwise go to LOOKUP.
- Pending flag:
  - node_reached in any state except IDLE/WAIT_NODE sets the flag.
  - A pulse while the flag is already set sets err[1]; the pulse counts once.
  - node_reached in IDLE is ignored.
- DONE (1 cycle): done=1, clear the flag, return to IDLE. err is kept until reset.
- in_ready=0 in LOOKUP through DONE.

## Timing

- Reset values: in_ready=0 during reset and 1 after reset release; all other outputs 0; state=IDLE; pointers 0; flag 0; err=00.
- Nodes are accepted at 1 per cycle.
- Last node accepted in cycle T: hd_req in T+1, hd_dir sampled in T+2, cmd_valid from T+3.
- node_reached in WAIT_NODE at cycle R: hd_req in R+1, cmd_valid in R+3.
- A pending flag in WAIT_NODE is consumed on that state's first cycle, with the same latency.
- Final node_reached in cycle R: done=1 in R+1, IDLE (in_ready=1) in R+2.
- Reset mid-operation drops everything immediately. cmd_valid falls asynchronously. No done pulse is issued.

## Test plan

- Path 33,31,28,3 (last), start_heading=N; ROM model: 33→31=E, 31→28=N, 28→3=W, 1-cycle latency -> cmds (31,right), (28,left), (3,left,last). Each issues only after the previous node_reached. done pulses 1 cycle after the third node_reached.
- Single node 7 with in_last -> no hd_req, no cmd_valid; done in the cycle after acceptance.
- cmd_ready held low 5 cycles in ISSUE -> cmd_turn, cmd_node and cmd_last are stable, and rd_ptr does not advance.
- node_reached pulsed while in ISSUE -> flag set; next LOOKUP follows WAIT_NODE entry with no further pulse. A second pulse before consumption -> err=10.
- 70-node path -> first 64 stored, err[0]=1, in_ready never drops, commands issued for 63 segments.
- Assert rst_n low during ISSUE -> all outputs 0 at once; after release a new 2-node path runs normally with err=00.
